// File: rtl/midi_tx_framer.sv
// MIDI message transmitter, 31250 baud 8N1 out of the 25 MHz synth clock.
// Accepts whole messages (status + up to two data bytes), applies running
// status, and slips single real-time bytes in at any byte boundary.

module midi_tx_framer #(
    parameter int unsigned CLK_DIV = 800,
    parameter bit          RS_EN   = 1'b1
) (
    input  logic       CLOCK_25,
    input  logic       reset_reg_N,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic       rt_valid,
    output logic       rt_ready,
    input  logic [7:0] rt_byte,
    output logic       midi_txd,
    output logic       busy,
    output logic [7:0] rs_active
);

    localparam int unsigned   CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Byte sequencer state and bit timing
    state_t          state_q,   state_d;
    logic [CW-1:0]   baud_q,    baud_d;
    logic [2:0]      bit_q,     bit_d;
    logic [7:0]      shreg_q,   shreg_d;

    // Remaining message bytes, entry 0 goes out next
    logic [2:0][7:0] mq_q,      mq_d;
    logic [1:0]      mq_cnt_q,  mq_cnt_d;

    // One-deep real-time slot and running-status register
    logic            rt_full_q, rt_full_d;
    logic [7:0]      rt_q,      rt_d;
    logic [7:0]      rs_q,      rs_d;

    logic            msg_acc;
    logic            rt_acc;
    logic            baud_last;
    logic            boundary;

    logic            is_voice;
    logic            is_common;
    logic            skip_status;
    logic [1:0]      msg_len;
    logic [7:0]      d1_m;
    logic [7:0]      d2_m;
    logic [7:0]      rs_new;
    logic [2:0][7:0] msg_list;
    logic [1:0]      msg_list_cnt;

    logic            load;
    logic [7:0]      load_byte;

    // Handshake strobes and byte-boundary timing
    always_comb begin
        msg_acc   = msg_valid && msg_ready;
        rt_acc    = rt_valid && rt_ready;
        baud_last = (baud_q == BAUD_LAST);
        boundary  = (state_q == IDLE) || ((state_q == STOP) && baud_last);
    end

    // Decode the offered message into the list of bytes that actually go out
    always_comb begin
        is_voice  = (msg_status >= 8'h80) && (msg_status <= 8'hEF);
        is_common = (msg_status >= 8'hF0) && (msg_status <= 8'hF7);
        d1_m      = msg_data1 & 8'h7F;
        d2_m      = msg_data2 & 8'h7F;

        msg_len = 2'd1;
        case (msg_status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: msg_len = 2'd3;
            4'hC, 4'hD:                   msg_len = 2'd2;
            4'hF: begin
                if (msg_status[3:0] == 4'h2) begin
                    msg_len = 2'd3;
                end else if ((msg_status[3:0] == 4'h1) || (msg_status[3:0] == 4'h3)) begin
                    msg_len = 2'd2;
                end
            end
            default: msg_len = 2'd1;
        endcase

        skip_status = RS_EN && is_voice && (msg_status == rs_q);

        rs_new = rs_q;
        if (RS_EN) begin
            if (is_voice) begin
                rs_new = msg_status;
            end else if (is_common) begin
                rs_new = '0;
            end
        end

        if (skip_status) begin
            msg_list     = {8'h00, d2_m, d1_m};
            msg_list_cnt = msg_len - 2'd1;
        end else begin
            msg_list     = {d2_m, d1_m, msg_status};
            msg_list_cnt = msg_len;
        end
    end

    // Pick the next byte at a boundary: real-time slot first, then the message
    // queue. A message accepted this cycle is loaded into the queue before the
    // pick so its first byte can start without an idle cycle; likewise a
    // real-time byte arriving on a boundary bypasses the slot.
    always_comb begin
        mq_d      = mq_q;
        mq_cnt_d  = mq_cnt_q;
        rt_full_d = rt_full_q;
        rt_d      = rt_q;
        rs_d      = rs_q;
        load      = 1'b0;
        load_byte = rt_q;

        if (msg_acc) begin
            mq_d     = msg_list;
            mq_cnt_d = msg_list_cnt;
            rs_d     = rs_new;
        end

        if (boundary) begin
            if (rt_full_q) begin
                load      = 1'b1;
                load_byte = rt_q;
                rt_full_d = 1'b0;
            end else if (rt_acc) begin
                load      = 1'b1;
                load_byte = rt_byte;
            end else if (mq_cnt_d != 2'd0) begin
                load      = 1'b1;
                load_byte = mq_d[0];
                mq_d      = {8'h00, mq_d[2:1]};
                mq_cnt_d  = mq_cnt_d - 2'd1;
            end
        end else if (rt_acc) begin
            rt_full_d = 1'b1;
            rt_d      = rt_byte;
        end
    end

    // Next-state logic of the byte sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = START;
            START:   if (baud_last) state_d = DATA;
            DATA:    if (baud_last && (bit_q == 3'd7)) state_d = STOP;
            STOP:    if (baud_last) state_d = load ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bit timer, bit index and data shifter
    always_comb begin
        baud_d  = ((state_q == IDLE) || baud_last) ? '0 : baud_q + CW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        if (baud_last && (state_q == START)) begin
            bit_d = '0;
        end
        if (baud_last && (state_q == DATA)) begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
        end
        if (load) begin
            shreg_d = load_byte;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        case (state_q)
            START:   midi_txd = 1'b0;
            DATA:    midi_txd = shreg_q[0];
            default: midi_txd = 1'b1;
        endcase
        msg_ready = (state_q == IDLE) && (mq_cnt_q == 2'd0);
        rt_ready  = !rt_full_q;
        busy      = (state_q != IDLE) || (mq_cnt_q != 2'd0);
        rs_active = rs_q;
    end

    // State register
    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            mq_q      <= '0;
            mq_cnt_q  <= '0;
            rt_full_q <= 1'b0;
            rt_q      <= '0;
            rs_q      <= '0;
        end else begin
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            mq_q      <= mq_d;
            mq_cnt_q  <= mq_cnt_d;
            rt_full_q <= rt_full_d;
            rt_q      <= rt_d;
            rs_q      <= rs_d;
        end
    end

endmodule

// File: tb/tb_midi_tx_framer.sv
// Bench for midi_tx_framer: directed plus randomized messages, serial line
// decoded back into bytes and compared with a message-level model.

module tb_midi_tx_framer;

    localparam int DIV = 16;
    localparam int FR  = 10 * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT a: running status on
    logic       msg_valid_a = 1'b0, msg_ready_a;
    logic [7:0] msg_status_a = '0, msg_data1_a = '0, msg_data2_a = '0;
    logic       rt_valid_a = 1'b0, rt_ready_a;
    logic [7:0] rt_byte_a = '0;
    logic       txd_a, busy_a;
    logic [7:0] rs_a;

    // DUT b: running status off
    logic       msg_valid_b = 1'b0, msg_ready_b;
    logic [7:0] msg_status_b = '0, msg_data1_b = '0, msg_data2_b = '0;
    logic       rt_valid_b = 1'b0, rt_ready_b;
    logic [7:0] rt_byte_b = '0;
    logic       txd_b, busy_b;
    logic [7:0] rs_b;

    midi_tx_framer #(.CLK_DIV(DIV), .RS_EN(1'b1)) dut_a (
        .CLOCK_25(clk), .reset_reg_N(rst_n),
        .msg_valid(msg_valid_a), .msg_ready(msg_ready_a),
        .msg_status(msg_status_a), .msg_data1(msg_data1_a), .msg_data2(msg_data2_a),
        .rt_valid(rt_valid_a), .rt_ready(rt_ready_a), .rt_byte(rt_byte_a),
        .midi_txd(txd_a), .busy(busy_a), .rs_active(rs_a)
    );

    midi_tx_framer #(.CLK_DIV(DIV), .RS_EN(1'b0)) dut_b (
        .CLOCK_25(clk), .reset_reg_N(rst_n),
        .msg_valid(msg_valid_b), .msg_ready(msg_ready_b),
        .msg_status(msg_status_b), .msg_data1(msg_data1_b), .msg_data2(msg_data2_b),
        .rt_valid(rt_valid_b), .rt_ready(rt_ready_b), .rt_byte(rt_byte_b),
        .midi_txd(txd_b), .busy(busy_b), .rs_active(rs_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cyc = 0;
    int lowcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Serial line receivers: one byte per frame, sampled near bit centres
    logic [7:0] rx_a[$], rx_b[$];
    int  mc_a = 0, mc_b = 0;
    bit  ma_a = 1'b0, mb_b = 1'b0;
    logic [7:0] sh_a = '0, sh_b = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ma_a <= 1'b0;
        end else if (!ma_a) begin
            if (txd_a === 1'b0) begin
                ma_a <= 1'b1;
                mc_a <= 0;
            end
        end else begin
            mc_a <= mc_a + 1;
            if (((mc_a + 1) % DIV == DIV / 2) && ((mc_a + 1) / DIV >= 1) && ((mc_a + 1) / DIV <= 8))
                sh_a <= {txd_a, sh_a[7:1]};
            if (mc_a + 1 == 9 * DIV + DIV / 2) begin
                rx_a.push_back(sh_a);
                ma_a <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            mb_b <= 1'b0;
        end else if (!mb_b) begin
            if (txd_b === 1'b0) begin
                mb_b <= 1'b1;
                mc_b <= 0;
            end
        end else begin
            mc_b <= mc_b + 1;
            if (((mc_b + 1) % DIV == DIV / 2) && ((mc_b + 1) / DIV >= 1) && ((mc_b + 1) / DIV <= 8))
                sh_b <= {txd_b, sh_b[7:1]};
            if (mc_b + 1 == 9 * DIV + DIV / 2) begin
                rx_b.push_back(sh_b);
                mb_b <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (rst_n && (txd_a === 1'b0)) lowcnt <= lowcnt + 1;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d required=finish", cyc);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_a[$], exp_b[$];
    logic [7:0] mlist[$];
    logic [7:0] m_rs = '0;
    int rd_a = 0, rd_b = 0;

    function automatic int msg_len(input logic [7:0] st);
        if (st >= 8'h80 && st <= 8'hEF) return (st >= 8'hC0 && st <= 8'hDF) ? 2 : 3;
        if (st == 8'hF2) return 3;
        if (st == 8'hF1 || st == 8'hF3) return 2;
        return 1;
    endfunction

    // Bytes a message puts on the wire, given the running-status history
    task automatic model_msg(input bit rs_en, input logic [7:0] st, d1, d2, output int n);
        int len;
        bit voice;
        len   = msg_len(st);
        voice = (st >= 8'h80 && st <= 8'hEF);
        mlist.delete();
        if (!(rs_en && voice && st == m_rs)) mlist.push_back(st);
        if (len >= 2) mlist.push_back(d1 & 8'h7F);
        if (len == 3) mlist.push_back(d2 & 8'h7F);
        if (rs_en) begin
            if (voice) m_rs = st;
            else if (st >= 8'hF0 && st <= 8'hF7) m_rs = 8'h00;
        end
        n = mlist.size();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? msg_ready_a : msg_ready_b;
    endfunction
    function automatic logic line(input int w);
        return (w == 0) ? txd_a : txd_b;
    endfunction
    function automatic logic bsy(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Offer one message (optionally with a same-cycle rt byte) and check the handshake
    task automatic send(input int w, input logic [7:0] st, d1, d2, input bit with_rt, input logic [7:0] rb);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy(w) && n < 20 * FR) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(w)) begin
            chk("ready_timeout", rdy(w), 1);
            return;
        end
        if (w == 0) begin
            msg_valid_a = 1'b1; msg_status_a = st; msg_data1_a = d1; msg_data2_a = d2;
            if (with_rt) begin rt_valid_a = 1'b1; rt_byte_a = rb; end
        end else begin
            msg_valid_b = 1'b1; msg_status_b = st; msg_data1_b = d1; msg_data2_b = d2;
        end
        @(posedge clk);
        @(negedge clk);
        hs_cyc = cyc;
        msg_valid_a = 1'b0; rt_valid_a = 1'b0; msg_valid_b = 1'b0;
        msg_status_a = 8'($urandom); msg_data1_a = 8'($urandom); msg_data2_a = 8'($urandom);
        rt_byte_a = 8'($urandom);
        msg_status_b = 8'($urandom); msg_data1_b = 8'($urandom); msg_data2_b = 8'($urandom);
        chk("ready_drop", rdy(w), 0);
        chk("start_latency", line(w), 0);
    endtask

    task automatic inject_rt(input logic [7:0] rb);
        rt_valid_a = 1'b1;
        rt_byte_a  = rb;
        @(posedge clk);
        @(negedge clk);
        rt_valid_a = 1'b0;
        rt_byte_a  = 8'($urandom);
        chk("rt_slot_full", rt_ready_a, 0);
    endtask

    task automatic wait_idle(input int w, output int dur);
        int n;
        n = 0;
        while (bsy(w) && n < 40 * FR) begin
            @(negedge clk);
            n++;
        end
        if (bsy(w)) chk("idle_timeout", bsy(w), 0);
        dur = cyc - hs_cyc;
    endtask

    task automatic check_a(input string tag);
        chk({tag, "_count"}, rx_a.size() - rd_a, exp_a.size());
        for (int i = 0; i < exp_a.size(); i++)
            if (rd_a + i < rx_a.size()) chk(tag, rx_a[rd_a + i], exp_a[i]);
        rd_a = rx_a.size();
        exp_a.delete();
    endtask

    task automatic check_b(input string tag);
        chk({tag, "_count"}, rx_b.size() - rd_b, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            if (rd_b + i < rx_b.size()) chk(tag, rx_b[rd_b + i], exp_b[i]);
        rd_b = rx_b.size();
        exp_b.delete();
    endtask

    // Full message on DUT a with no real-time traffic
    task automatic run_msg_a(input string tag, input logic [7:0] st, d1, d2);
        int n, dur;
        model_msg(1'b1, st, d1, d2, n);
        foreach (mlist[i]) exp_a.push_back(mlist[i]);
        send(0, st, d1, d2, 1'b0, 8'h00);
        wait_idle(0, dur);
        chk({tag, "_dur"}, dur, n * FR);
        check_a(tag);
        chk({tag, "_rs"}, rs_a, m_rs);
    endtask

    initial begin
        int n, dur, lc0, rxn;
        logic [7:0] st, d1, d2, rb;
        int j, off;
        bit inj;

        // Reset values
        repeat (4) @(negedge clk);
        chk("rst_txd", txd_a, 1);
        chk("rst_msg_ready", msg_ready_a, 1);
        chk("rst_rt_ready", rt_ready_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_rs", rs_a, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_txd", txd_a, 1);

        // Running-status sequence
        run_msg_a("note_on", 8'h90, 8'h3C, 8'h64);
        run_msg_a("rs_skip", 8'h90, 8'h3E, 8'h7F);
        run_msg_a("note_off", 8'h80, 8'h3E, 8'h00);
        run_msg_a("prog_chg", 8'hC5, 8'h0A, 8'h55);
        run_msg_a("song_pos", 8'hF2, 8'h01, 8'h02);
        run_msg_a("prog_again", 8'hC5, 8'h0B, 8'h00);

        // Real-time byte during the second frame of a message
        model_msg(1'b1, 8'h90, 8'h3C, 8'h64, n);
        exp_a.push_back(8'h90); exp_a.push_back(8'h3C); exp_a.push_back(8'hF8); exp_a.push_back(8'h64);
        send(0, 8'h90, 8'h3C, 8'h64, 1'b0, 8'h00);
        wait_cyc(hs_cyc + FR + FR / 2);
        inject_rt(8'hF8);
        wait_cyc(hs_cyc + 2 * FR - 1);
        chk("rt_ready_held", rt_ready_a, 0);
        wait_cyc(hs_cyc + 2 * FR);
        chk("rt_ready_freed", rt_ready_a, 1);
        chk("rt_start_bit", txd_a, 0);
        wait_idle(0, dur);
        chk("rt_mid_dur", dur, 4 * FR);
        check_a("rt_mid");
        chk("rt_mid_rs", rs_a, m_rs);

        // Simultaneous message and real-time byte from idle
        model_msg(1'b1, 8'hB0, 8'h07, 8'hFF, n);
        exp_a.push_back(8'hFA);
        foreach (mlist[i]) exp_a.push_back(mlist[i]);
        send(0, 8'hB0, 8'h07, 8'hFF, 1'b1, 8'hFA);
        wait_idle(0, dur);
        chk("same_cyc_dur", dur, 4 * FR);
        check_a("same_cyc");
        chk("same_cyc_rs", rs_a, m_rs);

        // Randomized messages with optional mid-message real-time bytes
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 9) < 7) st = {1'b1, 3'($urandom_range(0, 6)), 4'($urandom_range(0, 1))};
            else st = 8'($urandom);
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            model_msg(1'b1, st, d1, d2, n);
            inj = 1'($urandom_range(0, 1));
            rb  = {5'b11111, 3'($urandom)};
            j   = 0;
            off = 0;
            if (inj) begin
                j   = $urandom_range(0, n - 1);
                off = $urandom_range(2, FR - 4);
                mlist.insert(j + 1, rb);
            end
            foreach (mlist[i]) exp_a.push_back(mlist[i]);
            send(0, st, d1, d2, 1'b0, 8'h00);
            if (inj) begin
                wait_cyc(hs_cyc + j * FR + off);
                inject_rt(rb);
            end
            wait_idle(0, dur);
            chk("rand_dur", dur, mlist.size() * FR);
            check_a("rand_bytes");
            chk("rand_rs", rs_a, m_rs);
        end

        // Reset in the middle of a data bit with the rt slot occupied
        model_msg(1'b1, 8'hF2, 8'h00, 8'h00, n);
        send(0, 8'hF2, 8'h00, 8'h00, 1'b0, 8'h00);
        wait_cyc(hs_cyc + FR + DIV);
        inject_rt(8'hF9);
        wait_cyc(hs_cyc + FR + 3 * DIV + DIV / 2);
        chk("pre_reset_txd", txd_a, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", txd_a, 1);
        chk("mid_rst_msg_ready", msg_ready_a, 1);
        chk("mid_rst_rt_ready", rt_ready_a, 1);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_rs", rs_a, 8'h00);
        m_rs = 8'h00;
        exp_a.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lc0  = lowcnt;
        rd_a = rx_a.size();
        rxn  = rx_a.size();
        repeat (12 * FR) @(negedge clk);
        chk("residual_low", lowcnt - lc0, 0);
        chk("residual_bytes", rx_a.size() - rxn, 0);
        chk("residual_busy", busy_a, 0);
        run_msg_a("after_reset", 8'h90, 8'h3C, 8'h64);

        // Running status disabled: status byte every time
        chk("b_rst_rt_ready", rt_ready_b, 1);
        for (int k = 0; k < 3; k++) begin
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            model_msg(1'b0, 8'h90, d1, d2, n);
            foreach (mlist[i]) exp_b.push_back(mlist[i]);
            send(1, 8'h90, d1, d2, 1'b0, 8'h00);
            wait_idle(1, dur);
            chk("b_dur", dur, 3 * FR);
            check_b("b_bytes");
            chk("b_rs", rs_b, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_tx_framer.md
Name: midi_tx_framer

Overview:
- MIDI message transmitter at 31250 baud, the send-side counterpart of the MIDI UART receiver.
- Accepts whole channel/system messages (status plus up to two data bytes) over a valid/ready handshake.
- Derives the message length from the status byte, applies optional running status, and interleaves single-byte system real-time messages between bytes.
- Drives the MIDI out line from the synth's 25 MHz domain.

Parameters:
- CLK_DIV, 800, CLOCK_25 cycles per bit (25e6/31250).
- RS_EN, 1, running status enabled when 1.

Ports:
- CLOCK_25  in  1  system clock, 25 MHz; all logic on its rising edge.
- reset_reg_N  in  1  asynchronous active-low reset.
- msg_valid  in  1  message offered.
- msg_ready  out  1  framer can accept a message this cycle.
- msg_status  in  8  status byte, bit7 must be 1.
- msg_data1  in  8  first data byte; bit7 is ignored and sent as 0.
- msg_data2  in  8  second data byte; bit7 is ignored and sent as 0.
- rt_valid  in  1  real-time byte offered.
- rt_ready  out  1  real-time slot empty.
- rt_byte  in  8  real-time byte, F8..FF.
- midi_txd  out  1  serial out; idles high.
- busy  out  1  a frame is in progress or bytes remain queued.
- rs_active  out  8  current running-status byte; 00 when none.

Behaviour:
- Reset values: midi_txd=1, msg_ready=1, rt_ready=1, busy=0, rs_active=00.
- Reset mid-frame aborts immediately; the line returns high and all queued bytes are dropped.
- Message handshake: the message is accepted on a rising edge where msg_valid && msg_ready; all three message inputs are captured then.
  - msg_ready is high only in IDLE with no message bytes queued.
  - msg_ready drops the cycle after acceptance.
- Message length from msg_status:
  - 8n/9n/An/Bn/En and F2 send 3 bytes.
  - Cn/Dn, F1 and F3 send 2 bytes.
  - All other Fx values send 1 byte (status only).
- Running status (RS_EN=1):
  - For 80..EF, the status byte is skipped when it equals rs_active; otherwise it is sent and rs_active is set to it.
  - Any F0..F7 is always sent and clears rs_active to 00.
  - Real-time bytes never alter rs_active.
  - With RS_EN=0, the status byte is always sent and rs_active stays 00.
- Real-time handshake:
  - rt_byte is accepted into a one-deep slot on rt_valid && rt_ready; rt_ready is low while the slot is full.
  - At every byte boundary (IDLE, or end of a stop bit) the slot has priority over the next message byte, including mid-message.
  - The slot empties when its frame begins.
- Byte sequencer states:
  - IDLE: waits for a queued rt byte or message byte, then goes to START.
  - START: midi_txd=0 for CLK_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; bit index 0..7, then STOP.
  - STOP: midi_txd=1 for CLK_DIV cycles. Then the next queued byte goes straight to START with no idle gap; with nothing queued, return to IDLE.
- Frame timing:
  - The bit counter runs 0..CLK_DIV-1; each frame is exactly 10*CLK_DIV cycles.
  - The start bit begins the cycle after the handshake edge when IDLE; that cycle is the latency from handshake to line low.
- busy is high from the first START cycle (or message acceptance) until return to IDLE.
- Simultaneous msg and rt acceptance in IDLE: the rt byte is sent first, then the message.
- Inputs must not change the queued data after acceptance.
- Protocol errors are not flagged:
  - A status input with bit7=0 is transmitted as given with length 1.
  - rt_byte values below F8 are transmitted as given.

Test Plan:
- Reset, then msg 90 3C 64: line low 1 cycle after handshake; 3 frames 90,3C,64 back-to-back, each 8000 cycles; busy low after 24000 cycles; rs_active=90.
- Second msg 90 3E 7F: only 3E,7F sent (16000 cycles). Then 80 3E 00: 80,3E,00 sent; rs_active=80.
- Msg C5 0A 55 (data2 ignored): 2 frames C5,0A. Then msg F2 01 02: F2,01,02 sent and rs_active=00. Then C5 0B: C5 resent.
- rt F8 asserted during the 3C frame of 90 3C 64: sequence is 90,3C,F8,64; rt_ready low until the F8 start bit; rs_active unchanged.
- Same-cycle msg B0 07 FF and rt FA in IDLE: FA,B0,07,7F sent; data2 bit7 is forced 0.
- Reset asserted mid-data-bit of a frame: midi_txd=1 immediately; msg_ready/rt_ready=1; no residual bytes after release. With RS_EN=0, repeated 90 messages always include the status byte.
